gfx_command_parser: RTL and testbench



---
 rtl/gfx_command_parser.sv | 259 +++++++++++++++++++++++++
 tb/tb_gfx_command_parser.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_command_parser.sv
// gfx_command_parser: decodes a UART byte stream into pixel, palette, rectangle-fill and clear writes.
// Optional trailing XOR checksum byte per command: define GFX_CMD_PARSER_CHECKSUM_EN.
`default_nettype none
module gfx_command_parser #(
    parameter int FB_WIDTH       = 320,
    parameter int FB_HEIGHT      = 200,
    parameter int X_BITS         = 9,
    parameter int Y_BITS         = 8,
    parameter int COLOR_BITS     = 8,
    parameter int PAL_CH_BITS    = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             uart_data,
    input  logic                   uart_data_valid,
    output logic                   parser_ready,
    output logic                   fb_write_enable,
    input  logic                   fb_write_ready,
    output logic [X_BITS-1:0]      fb_write_x,
    output logic [Y_BITS-1:0]      fb_write_y,
    output logic [COLOR_BITS-1:0]  fb_write_data,
    output logic                   palette_write_enable,
    output logic [COLOR_BITS-1:0]  palette_index,
    output logic [PAL_CH_BITS-1:0] palette_r,
    output logic [PAL_CH_BITS-1:0] palette_g,
    output logic [PAL_CH_BITS-1:0] palette_b,
    output logic                   busy,
    output logic                   cmd_error,
    output logic [1:0]             error_code
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        WAIT_CMD     = 3'd0,
        RX_ARGS      = 3'd1,
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
        RX_CHK       = 3'd2,
`endif
        EXEC_PALETTE = 3'd3,
        WRITE_PIXEL  = 3'd4,
        FILL         = 3'd5
    } state_t;

    state_t state, state_n, exec_state;
    logic [7:0]  opcode;
    logic [7:0]  args   [0:8];
    logic [7:0]  args_n [0:8];
    logic [3:0]  cnt, nargs;
    logic [TW-1:0] tcnt;
    logic [15:0] cur_x, cur_y, x_start;
    logic [16:0] x_end, y_end;
    logic        active;
    logic        accept, last_arg, dispatch, timeout_hit, wr_acc, step_x, step_y, err_set;
    logic [1:0]  err_code_n;
    logic [15:0] d_x, d_y, d_w, d_h;
    logic [COLOR_BITS-1:0] d_col;
    logic [16:0] sum_x, sum_y, d_xe, d_ye;
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
    logic [7:0]  chk;

    assign parser_ready = (state == WAIT_CMD) || (state == RX_ARGS) || (state == RX_CHK);
    assign dispatch     = (state == RX_CHK) && accept && (uart_data == chk);
`else
    assign parser_ready = (state == WAIT_CMD) || (state == RX_ARGS);
    assign dispatch     = last_arg;
`endif

    assign accept          = uart_data_valid && parser_ready;
    assign last_arg        = (state == RX_ARGS) && accept && (cnt == nargs - 4'd1);
    assign timeout_hit     = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy            = (state != WAIT_CMD);
    assign fb_write_enable = ((state == WRITE_PIXEL) || (state == FILL)) && active;
    assign palette_write_enable = (state == EXEC_PALETTE);
    assign wr_acc          = fb_write_enable && fb_write_ready;
    assign step_x          = wr_acc && (({1'b0, cur_x} + 17'd1) < x_end);
    assign step_y          = wr_acc && !step_x && (({1'b0, cur_y} + 17'd1) < y_end);
    assign fb_write_x      = cur_x[X_BITS-1:0];
    assign fb_write_y      = cur_y[Y_BITS-1:0];

    always_comb begin
        case (opcode)
            8'h01:   nargs = 4'd5;
            8'h02:   nargs = 4'd4;
            8'h03:   nargs = 4'd9;
            default: nargs = 4'd1;
        endcase
        case (opcode)
            8'h01:   exec_state = WRITE_PIXEL;
            8'h02:   exec_state = EXEC_PALETTE;
            default: exec_state = FILL;
        endcase
    end

    // Argument view including the byte being accepted, so execution can launch on the same edge.
    always_comb begin
        for (int i = 0; i < 9; i++) args_n[i] = args[i];
        if ((state == RX_ARGS) && accept) args_n[cnt] = uart_data;
    end

    // A single pixel is a 1x1 rectangle; CLEAR is a full-screen rectangle.
    always_comb begin
        d_x   = {args_n[0], args_n[1]};
        d_y   = {args_n[2], args_n[3]};
        d_w   = 16'd1;
        d_h   = 16'd1;
        d_col = args_n[4][COLOR_BITS-1:0];
        case (opcode)
            8'h03: begin
                d_w   = {args_n[4], args_n[5]};
                d_h   = {args_n[6], args_n[7]};
                d_col = args_n[8][COLOR_BITS-1:0];
            end
            8'h04: begin
                d_x   = 16'd0;
                d_y   = 16'd0;
                d_w   = 16'(FB_WIDTH);
                d_h   = 16'(FB_HEIGHT);
                d_col = args_n[0][COLOR_BITS-1:0];
            end
            default: ;
        endcase
    end

    assign sum_x = {1'b0, d_x} + {1'b0, d_w};
    assign sum_y = {1'b0, d_y} + {1'b0, d_h};
    assign d_xe  = (sum_x > 17'(FB_WIDTH))  ? 17'(FB_WIDTH)  : sum_x;
    assign d_ye  = (sum_y > 17'(FB_HEIGHT)) ? 17'(FB_HEIGHT) : sum_y;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_CMD;
        else          state <= state_n;
    end

    always_comb begin
        state_n    = state;
        err_set    = 1'b0;
        err_code_n = error_code;
        case (state)
            WAIT_CMD: begin
                if (accept) begin
                    if ((uart_data >= 8'h01) && (uart_data <= 8'h04)) begin
                        state_n = RX_ARGS;
                    end else begin
                        err_set    = 1'b1;
                        err_code_n = 2'd1;
                    end
                end
            end
            RX_ARGS: begin
                if (timeout_hit && !accept) begin
                    err_set    = 1'b1;
                    err_code_n = 2'd2;
                    state_n    = WAIT_CMD;
                end else if (last_arg) begin
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
                    state_n = RX_CHK;
`else
                    state_n = exec_state;
`endif
                end
            end
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
            RX_CHK: begin
                if (timeout_hit && !accept) begin
                    err_set    = 1'b1;
                    err_code_n = 2'd2;
                    state_n    = WAIT_CMD;
                end else if (accept) begin
                    if (uart_data == chk) begin
                        state_n = exec_state;
                    end else begin
                        err_set    = 1'b1;
                        err_code_n = 2'd3;
                        state_n    = WAIT_CMD;
                    end
                end
            end
`endif
            EXEC_PALETTE: state_n = WAIT_CMD;
            WRITE_PIXEL, FILL: begin
                if (!active || (wr_acc && !step_x && !step_y)) state_n = WAIT_CMD;
            end
            default: state_n = WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opcode        <= 8'd0;
            for (int i = 0; i < 9; i++) args[i] <= 8'd0;
            cnt           <= 4'd0;
            tcnt          <= '0;
            cur_x         <= 16'd0;
            cur_y         <= 16'd0;
            x_start       <= 16'd0;
            x_end         <= 17'd0;
            y_end         <= 17'd0;
            active        <= 1'b0;
            fb_write_data <= '0;
            palette_index <= '0;
            palette_r     <= '0;
            palette_g     <= '0;
            palette_b     <= '0;
            cmd_error     <= 1'b0;
            error_code    <= 2'd0;
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
            chk           <= 8'd0;
`endif
        end else begin
            cmd_error <= err_set;
            if (err_set) error_code <= err_code_n;

            if (accept || (state == WAIT_CMD) || !parser_ready) tcnt <= '0;
            else                                                tcnt <= tcnt + 1'b1;

            if ((state == WAIT_CMD) && accept) begin
                opcode <= uart_data;
                cnt    <= 4'd0;
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
                chk    <= uart_data;
`endif
            end
            if ((state == RX_ARGS) && accept) begin
                args[cnt] <= uart_data;
                cnt       <= cnt + 4'd1;
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
                chk       <= chk ^ uart_data;
`endif
            end

            if (dispatch) begin
                if (opcode == 8'h02) begin
                    palette_index <= args_n[0][COLOR_BITS-1:0];
                    palette_r     <= args_n[1][7 -: PAL_CH_BITS];
                    palette_g     <= args_n[2][7 -: PAL_CH_BITS];
                    palette_b     <= args_n[3][7 -: PAL_CH_BITS];
                end else begin
                    cur_x         <= d_x;
                    x_start       <= d_x;
                    cur_y         <= d_y;
                    x_end         <= d_xe;
                    y_end         <= d_ye;
                    fb_write_data <= d_col;
                    // Empty after clipping covers w=0, h=0 and off-screen origins.
                    active        <= (d_xe > {1'b0, d_x}) && (d_ye > {1'b0, d_y});
                end
            end else if (step_x) begin
                cur_x <= cur_x + 16'd1;
            end else if (step_y) begin
                cur_x <= x_start;
                cur_y <= cur_y + 16'd1;
            end else if (wr_acc) begin
                active <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gfx_command_parser.sv
// Bench for gfx_command_parser: directed and random commands against a queue-based command model.
`timescale 1ns/1ps
module tb_gfx_command_parser;
    localparam int W  = 320;
    localparam int H  = 200;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] uart_data = 8'd0;
    logic       uart_data_valid = 1'b0;
    logic       fb_write_ready = 1'b0;
    logic       parser_ready, fb_write_enable, palette_write_enable, busy, cmd_error;
    logic [8:0] fb_write_x;
    logic [7:0] fb_write_y, fb_write_data, palette_index;
    logic [3:0] palette_r, palette_g, palette_b;
    logic [1:0] error_code;

    gfx_command_parser #(
        .FB_WIDTH(W), .FB_HEIGHT(H), .X_BITS(9), .Y_BITS(8),
        .COLOR_BITS(8), .PAL_CH_BITS(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .uart_data(uart_data), .uart_data_valid(uart_data_valid), .parser_ready(parser_ready),
        .fb_write_enable(fb_write_enable), .fb_write_ready(fb_write_ready),
        .fb_write_x(fb_write_x), .fb_write_y(fb_write_y), .fb_write_data(fb_write_data),
        .palette_write_enable(palette_write_enable), .palette_index(palette_index),
        .palette_r(palette_r), .palette_g(palette_g), .palette_b(palette_b),
        .busy(busy), .cmd_error(cmd_error), .error_code(error_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [24:0] exp_wr[$];
    logic [19:0] exp_pal[$];
    logic [1:0]  exp_err[$];
    logic [7:0]  cmd[$];
    int          rdy_mode = 0;
    int          rdy_low_cnt = 0;
    logic        stall_prev = 1'b0;
    logic        idle_next = 1'b0;
    logic        accepted = 1'b0;
    logic [24:0] held = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock: sample everything on the falling edge, return just after the rising edge.
    task automatic cyc();
        if (rdy_mode == 1) fb_write_ready = ($urandom_range(0, 99) < 65);
        @(negedge clk);
        accepted = uart_data_valid && parser_ready;
        if (!parser_ready) rdy_low_cnt++;
        if (idle_next) begin
            check("busy_after_last", 32'(busy), 32'd0);
            idle_next = 1'b0;
        end
        if (stall_prev)
            check("stall_hold", 32'({fb_write_enable, fb_write_x, fb_write_y, fb_write_data}), 32'({1'b1, held}));
        if (fb_write_enable && fb_write_ready) begin
            check("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
            if (exp_wr.size() != 0) begin
                check("wr", 32'({fb_write_x, fb_write_y, fb_write_data}), 32'(exp_wr.pop_front()));
                if (exp_wr.size() == 0) idle_next = 1'b1;
            end
        end
        stall_prev = fb_write_enable && !fb_write_ready;
        held = {fb_write_x, fb_write_y, fb_write_data};
        if (palette_write_enable) begin
            check("pal_expected", 32'(exp_pal.size() != 0), 32'd1);
            if (exp_pal.size() != 0)
                check("pal", 32'({palette_index, palette_r, palette_g, palette_b}), 32'(exp_pal.pop_front()));
        end
        if (cmd_error) begin
            check("err_expected", 32'(exp_err.size() != 0), 32'd1);
            if (exp_err.size() != 0) check("err_code", 32'(error_code), 32'(exp_err.pop_front()));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_data = b;
        uart_data_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (accepted) break;
        end
        check("byte_accept", 32'(accepted), 32'd1);
        uart_data_valid = 1'b0;
    endtask

    // Expected effect of the command in cmd[], derived from the command definitions.
    task automatic model_cmd();
        int unsigned x, y, w, h, xe, ye;
        logic [7:0] c;
        case (cmd[0])
            8'h01: begin
                x = {cmd[1], cmd[2]}; y = {cmd[3], cmd[4]}; c = cmd[5];
                if (x < W && y < H) exp_wr.push_back({x[8:0], y[7:0], c});
            end
            8'h02: exp_pal.push_back({cmd[1], cmd[2][7:4], cmd[3][7:4], cmd[4][7:4]});
            8'h03, 8'h04: begin
                if (cmd[0] == 8'h03) begin
                    x = {cmd[1], cmd[2]}; y = {cmd[3], cmd[4]};
                    w = {cmd[5], cmd[6]}; h = {cmd[7], cmd[8]}; c = cmd[9];
                end else begin
                    x = 0; y = 0; w = W; h = H; c = cmd[1];
                end
                xe = (x + w > W) ? W : x + w;
                ye = (y + h > H) ? H : y + h;
                for (int unsigned yy = y; yy < ye; yy++)
                    for (int unsigned xx = x; xx < xe; xx++)
                        exp_wr.push_back({xx[8:0], yy[7:0], c});
            end
            default: exp_err.push_back(2'd1);
        endcase
    endtask

    task automatic send_cmd(input int gaps);
        logic [7:0] x;
        x = 8'd0;
        foreach (cmd[i]) begin
            if (gaps != 0) repeat ($urandom_range(0, 2)) cyc();
            send_byte(cmd[i]);
            x ^= cmd[i];
        end
`ifdef GFX_CMD_PARSER_CHECKSUM_EN
        if (cmd[0] >= 8'h01 && cmd[0] <= 8'h04) send_byte(x);
`endif
        model_cmd();
    endtask

    task automatic wait_idle();
        cyc();
        cyc();
        for (int i = 0; i < 70000; i++) begin
            if (!busy) break;
            cyc();
        end
        check("idle", 32'(busy), 32'd0);
        cyc();
    endtask

    task automatic fill_cmd(input int x, input int y, input int w, input int h, input logic [7:0] c);
        cmd = {8'h03, 8'(x >> 8), 8'(x), 8'(y >> 8), 8'(y), 8'(w >> 8), 8'(w), 8'(h >> 8), 8'(h), c};
    endtask

    initial begin
        int kind, rx, ry;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(parser_ready), 32'd1);
        check("rst_outs", 32'({busy, fb_write_enable, palette_write_enable, cmd_error, error_code}), 32'd0);
        check("rst_fb", 32'({fb_write_x, fb_write_y, fb_write_data}), 32'd0);
        check("rst_pal", 32'({palette_index, palette_r, palette_g, palette_b}), 32'd0);
        reset_n = 1'b1;
        fb_write_ready = 1'b1;
        cyc();

        cmd = {8'h01, 8'h00, 8'h0A, 8'h00, 8'h14, 8'h2C};
        rdy_low_cnt = 0;
        send_cmd(0);
        wait_idle();
        check("pixel_ready_low", 32'(rdy_low_cnt), 32'd1);

        cmd = {8'h02, 8'h05, 8'hF0, 8'h80, 8'h1F};
        send_cmd(0);
        wait_idle();

        fill_cmd(318, 198, 4, 4, 8'h07);
        send_cmd(0);
        wait_idle();
        rdy_mode = 1;
        fill_cmd(318, 198, 4, 4, 8'h07);
        send_cmd(0);
        wait_idle();
        rdy_mode = 0;
        fb_write_ready = 1'b1;

        cmd = {8'h7F};
        send_cmd(0);
        wait_idle();
        check("err_unknown", 32'(error_code), 32'd1);

        send_byte(8'h01);
        send_byte(8'h00);
        exp_err.push_back(2'd2);
        repeat (TO + 4) cyc();
        check("timeout_seen", 32'(exp_err.size()), 32'd0);
        check("timeout_code", 32'(error_code), 32'd2);
        check("timeout_idle", 32'(busy), 32'd0);
        cmd = {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        send_cmd(0);
        wait_idle();

`ifdef GFX_CMD_PARSER_CHECKSUM_EN
        cmd = {8'h01, 8'h00, 8'h01, 8'h00, 8'h01, 8'h09};
        send_cmd(0);
        wait_idle();
        foreach (cmd[i]) send_byte(cmd[i]);
        send_byte(8'h00);
        exp_err.push_back(2'd3);
        wait_idle();
        check("chk_code", 32'(error_code), 32'd3);
`endif

        fill_cmd(0, 0, 16'hFFFF, 1, 8'h33);
        send_cmd(0);
        wait_idle();
        fill_cmd(5, 5, 0, 3, 8'h44);
        send_cmd(0);
        wait_idle();

        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 4);
            rx = $urandom_range(0, 325);
            ry = $urandom_range(0, 205);
            case (kind)
                0: cmd = {8'h01, 8'(rx >> 8), 8'(rx), 8'(ry >> 8), 8'(ry), 8'($urandom)};
                1: cmd = {8'h02, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
                2: fill_cmd(rx, ry, $urandom_range(0, 6), $urandom_range(0, 4), 8'($urandom));
                3: cmd = {8'($urandom_range(5, 255))};
                default: fill_cmd($urandom_range(300, 325), $urandom_range(195, 199),
                                  ($urandom_range(0, 3) == 0) ? 16'hFFFF : $urandom_range(1, 8),
                                  $urandom_range(1, 6), 8'($urandom));
            endcase
            send_cmd(1);
            wait_idle();
        end
        rdy_mode = 0;
        fb_write_ready = 1'b1;

        cmd = {8'h04, 8'h00};
        send_cmd(0);
        wait_idle();

        fill_cmd(0, 0, 10, 10, 8'h05);
        send_cmd(0);
        repeat (5) cyc();
        reset_n = 1'b0;
        exp_wr.delete();
        idle_next = 1'b0;
        stall_prev = 1'b0;
        repeat (3) cyc();
        check("abort_en", 32'({fb_write_enable, busy}), 32'd0);
        reset_n = 1'b1;
        repeat (20) cyc();
        check("abort_idle", 32'({busy, error_code}), 32'd0);

        check("left_wr", 32'(exp_wr.size()), 32'd0);
        check("left_pal", 32'(exp_pal.size()), 32'd0);
        check("left_err", 32'(exp_err.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
